// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 2**N requesters with a binary grant index and a registered one-hot select.
// Define ARB_TIMEOUT_EN to build the hold counter that force-releases a grant after HOLD_MAX cycles.
module decoder_rr_arbiter #(
    parameter int N        = 3,
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [(1<<N)-1:0]   req,
    input  logic                done,
    output logic                gnt_valid,
    output logic [N-1:0]        gnt_idx,
    output logic [(1<<N)-1:0]   gnt_onehot,
    output logic                timeout
);
    localparam int NREQ = 1 << N;

    generate
        if (HOLD_MAX < 2 || (64'd1 << CNT_W) < 64'(HOLD_MAX)) begin : g_bad_params
            $error("decoder_rr_arbiter: HOLD_MAX must be in 2..2**CNT_W");
        end
    endgenerate

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_reg, state_next;
    logic [N-1:0]      ptr_reg, ptr_next;
    logic              gnt_valid_reg, gnt_valid_next;
    logic [N-1:0]      gnt_idx_reg, gnt_idx_next;
    logic [NREQ-1:0]   gnt_onehot_reg, gnt_onehot_next;
    logic              timeout_reg, timeout_next;

    logic              sel_found;
    logic [N-1:0]      sel_idx;
    logic [N-1:0]      cand;
    logic              owner_release;
    logic              force_release;

    // Scan from ptr upward with natural N-bit wrap; first pending request wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_reg;
        cand      = ptr_reg;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_reg + N'(k);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign owner_release = done || !req[gnt_idx_reg];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

    assign force_release = !owner_release && (hold_cnt_reg == CNT_W'(HOLD_MAX - 1));
    // Counts GRANT cycles; any cycle outside an ongoing grant restarts it at zero.
    assign hold_cnt_next = (state_reg == GRANT && state_next == GRANT) ? hold_cnt_reg + 1'b1
                                                                       : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
        end
    end
`else
    assign force_release = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        gnt_valid_next = gnt_valid_reg;
        gnt_idx_next   = gnt_idx_reg;
        timeout_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    state_next     = GRANT;
                    gnt_valid_next = 1'b1;
                    gnt_idx_next   = sel_idx;
                end
            end
            GRANT: begin
                if (owner_release || force_release) begin
                    state_next     = IDLE;
                    gnt_valid_next = 1'b0;
                    gnt_idx_next   = '0;
                    ptr_next       = gnt_idx_reg + 1'b1;
                    timeout_next   = force_release;
                end
            end
            default: begin
                state_next     = IDLE;
                gnt_valid_next = 1'b0;
                gnt_idx_next   = '0;
            end
        endcase
    end

    // Enabled N-to-2**N decode of the next index, gated by next grant-valid.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dec
            assign gnt_onehot_next[gi] = gnt_valid_next && (gnt_idx_next == N'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            gnt_valid_reg  <= 1'b0;
            gnt_idx_reg    <= '0;
            gnt_onehot_reg <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            gnt_valid_reg  <= gnt_valid_next;
            gnt_idx_reg    <= gnt_idx_next;
            gnt_onehot_reg <= gnt_onehot_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign gnt_valid  = gnt_valid_reg;
    assign gnt_idx    = gnt_idx_reg;
    assign gnt_onehot = gnt_onehot_reg;
    assign timeout    = timeout_reg;

endmodule
